// File: rtl/clk_enable_scheduler_pkg.sv
// rtl/clk_enable_scheduler_pkg.sv - shared types and constants for the clock-enable scheduler
// Purpose: config FSM state encoding, default divisor, counter width and
//          channel-index width used by the scheduler top and its rate channels.
package clk_enable_scheduler_pkg;

    localparam int CFG_W       = 16;
    localparam int CFG_DEF_DIV = 10;
    localparam int CH_IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/clk_enable_scheduler_rate_channel.sv
// rtl/clk_enable_scheduler_rate_channel.sv - one divider channel: strobe and square wave
// Purpose: counts 0..div-1, emits a registered one-cycle strobe after each wrap
//          and toggles a square wave with it. A pending divisor is taken only at
//          the period boundary (or at once when the channel is disabled).
// Ports:
//   clk         fabric clock
//   rst         synchronous active-high reset
//   load_i      a new divisor is pending for this channel
//   div_i       the pending divisor
//   resync_i    restart the counter and clear the square wave
//   applied_o   the pending divisor is taken at this edge
//   en_pulse_o  one-cycle enable strobe
//   clk_sq_o    square wave, period 2*div
module clk_enable_scheduler_rate_channel
    import clk_enable_scheduler_pkg::*;
#(
    parameter int W       = CFG_W,
    parameter int DEF_DIV = CFG_DEF_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] div_i,
    input  logic         resync_i,
    output logic         applied_o,
    output logic         en_pulse_o,
    output logic         clk_sq_o
);

    localparam logic [W-1:0] DEF_DIV_L = W'(DEF_DIV);

    logic [W-1:0] div_q, div_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         en_q, en_d;
    logic         sq_q, sq_d;
    logic         div_zero;
    logic         wrap;

    assign div_zero  = (div_q == '0);
    // div-1 is only evaluated when div is nonzero, so it can never underflow.
    assign wrap      = !div_zero && (cnt_q == (div_q - W'(1)));
    assign applied_o = load_i && (wrap || div_zero);

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        en_d  = 1'b0;
        sq_d  = sq_q;
        if (div_zero) begin
            cnt_d = '0;
        end else begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
            en_d  = wrap;
            sq_d  = sq_q ^ wrap;
        end
        // The strobe of the completing old period still fires on an apply.
        if (applied_o) begin
            div_d = div_i;
            cnt_d = '0;
        end
        // Resync overrides phase but keeps any divisor loaded in the same cycle.
        if (resync_i) begin
            cnt_d = '0;
            en_d  = 1'b0;
            sq_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= DEF_DIV_L;
            cnt_q <= '0;
            en_q  <= 1'b0;
            sq_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
            sq_q  <= sq_d;
        end
    end

    assign en_pulse_o = en_q;
    assign clk_sq_o   = sq_q;

endmodule

// File: rtl/clk_enable_scheduler.sv
// rtl/clk_enable_scheduler.sv - programmable per-channel clock-enable scheduler
// Purpose: N_CH rate channels with run-time divisor updates through a
//          valid/ready config port; updates land on period boundaries.
// Ports:
//   clk, rst            fabric clock, synchronous active-high reset
//   cfg_valid/cfg_ready config request handshake
//   cfg_ch, cfg_div     target channel and new divisor (0 disables)
//   cfg_done, cfg_err   completion pulse, error pulse for a bad channel index
//   resync              phase-align all channels
//   en_pulse, clk_sq    per-channel strobe and square wave
module clk_enable_scheduler
    import clk_enable_scheduler_pkg::*;
#(
    parameter int N_CH    = 3,
    parameter int W       = CFG_W,
    parameter int DEF_DIV = CFG_DEF_DIV
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [W-1:0]        cfg_div,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic                resync,
    output logic [N_CH-1:0]     en_pulse,
    output logic [N_CH-1:0]     clk_sq
);

    localparam logic [CH_IDX_W:0] N_CH_L = (CH_IDX_W+1)'(N_CH);

    cfg_state_e          state_q, state_d;
    logic [CH_IDX_W-1:0] ch_q, ch_d;
    logic [W-1:0]        div_q, div_d;
    logic                err_q, err_d;
    logic [N_CH-1:0]     load;
    logic [N_CH-1:0]     applied;

    assign cfg_ready = (state_q == ST_IDLE) && !rst;
    assign cfg_done  = (state_q == ST_DONE);
    assign cfg_err   = (state_q == ST_DONE) && err_q;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        div_d   = div_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    ch_d    = cfg_ch;
                    div_d   = cfg_div;
                    err_d   = ({1'b0, cfg_ch} >= N_CH_L);
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // A bad index touches no channel and completes right away.
                if (err_q || (|applied)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            div_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            div_q   <= div_d;
            err_q   <= err_d;
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign load[gi] = (state_q == ST_PEND) && !err_q && (ch_q == CH_IDX_W'(gi));

        clk_enable_scheduler_rate_channel #(
            .W       (W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load[gi]),
            .div_i      (div_q),
            .resync_i   (resync),
            .applied_o  (applied[gi]),
            .en_pulse_o (en_pulse[gi]),
            .clk_sq_o   (clk_sq[gi])
        );
    end

endmodule
